// File: rtl/food_placer.sv
// Food placement engine: draws LFSR candidates, range-checks them against the playfield,
// asks the snake-body occupancy checker, and retries until a free cell or MAX_TRIES rejections.
module food_placer #(
   parameter int unsigned GRID_W    = 64,
   parameter int unsigned GRID_H    = 48,
   parameter int unsigned MAX_TRIES = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       place_req,
   input  logic [9:0] rnd_x,
   input  logic [9:0] rnd_y,
   output logic       lfsr_en,
   output logic       occ_query,
   output logic [5:0] occ_x,
   output logic [5:0] occ_y,
   input  logic       occ_valid,
   input  logic       occ_hit,
   output logic [5:0] food_x,
   output logic [5:0] food_y,
   output logic       food_valid,
   output logic       busy,
   output logic       fail
);

   typedef enum logic [1:0] {StIdle, StSample, StQuery, StWait} state_e;

   state_e     state_q, state_d;
   logic [7:0] tries_q, tries_d;
   logic       in_range, reject, last_try;

   logic       lfsr_en_d, occ_query_d, busy_d, fail_d, food_valid_d;
   logic       lfsr_en_q, occ_query_q, busy_q, fail_q, food_valid_q;
   logic [5:0] occ_x_d, occ_y_d, food_x_d, food_y_d;
   logic [5:0] occ_x_q, occ_y_q, food_x_q, food_y_q;

   // Only the low six LFSR bits address the grid.
   logic unused_rnd_hi;
   assign unused_rnd_hi = ^{rnd_x[9:6], rnd_y[9:6]};

   assign in_range = ({1'b0, rnd_x[5:0]} < 7'(GRID_W)) && ({1'b0, rnd_y[5:0]} < 7'(GRID_H));

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         tries_q <= 8'd0;
      end else begin
         state_q <= state_d;
         tries_q <= tries_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      tries_d  = tries_q;
      reject   = 1'b0;
      last_try = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (place_req) begin
               state_d = StSample;
               tries_d = 8'd0;
            end
         end
         StSample: begin
            if (in_range) state_d = StQuery;
            else          reject  = 1'b1;
         end
         StQuery: state_d = StWait;
         StWait: begin
            if (occ_valid) begin
               if (occ_hit) reject  = 1'b1;
               else         state_d = StIdle;
            end
         end
      endcase
      if (reject) begin
         tries_d  = tries_q + 8'd1;
         last_try = (tries_d == 8'(MAX_TRIES));
         state_d  = last_try ? StIdle : StSample;
      end
   end

   // Output logic, computed from the upcoming state so every output leaves a flop
   always_comb begin
      lfsr_en_d    = (state_d == StSample);
      occ_query_d  = (state_d == StQuery);
      busy_d       = (state_d != StIdle);
      fail_d       = last_try;
      occ_x_d      = occ_x_q;
      occ_y_d      = occ_y_q;
      food_x_d     = food_x_q;
      food_y_d     = food_y_q;
      food_valid_d = food_valid_q;
      if (state_q == StIdle && place_req) food_valid_d = 1'b0;
      // Candidate is captured from the pre-advance LFSR value seen during SAMPLE.
      if (state_q == StSample && in_range) begin
         occ_x_d = rnd_x[5:0];
         occ_y_d = rnd_y[5:0];
      end
      if (state_q == StWait && occ_valid && !occ_hit) begin
         food_x_d     = occ_x_q;
         food_y_d     = occ_y_q;
         food_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr_en_q    <= 1'b0;
         occ_query_q  <= 1'b0;
         busy_q       <= 1'b0;
         fail_q       <= 1'b0;
         occ_x_q      <= 6'd0;
         occ_y_q      <= 6'd0;
         food_x_q     <= 6'd0;
         food_y_q     <= 6'd0;
         food_valid_q <= 1'b0;
      end else begin
         lfsr_en_q    <= lfsr_en_d;
         occ_query_q  <= occ_query_d;
         busy_q       <= busy_d;
         fail_q       <= fail_d;
         occ_x_q      <= occ_x_d;
         occ_y_q      <= occ_y_d;
         food_x_q     <= food_x_d;
         food_y_q     <= food_y_d;
         food_valid_q <= food_valid_d;
      end
   end

   assign lfsr_en    = lfsr_en_q;
   assign occ_query  = occ_query_q;
   assign busy       = busy_q;
   assign fail       = fail_q;
   assign occ_x      = occ_x_q;
   assign occ_y      = occ_y_q;
   assign food_x     = food_x_q;
   assign food_y     = food_y_q;
   assign food_valid = food_valid_q;

endmodule

// File: tb/tb_food_placer.sv
// Bench for food_placer: directed and randomized placements checked against a
// candidate-list reference model of the placement rules.
module tb_food_placer;

   localparam int GW = 64;
   localparam int GH = 48;
   localparam int MT = 255;

   logic       clk = 1'b0;
   logic       rst_n, place_req, occ_valid, occ_hit;
   logic [9:0] rnd_x, rnd_y;
   logic       lfsr_en, occ_query, food_valid, busy, fail;
   logic [5:0] occ_x, occ_y, food_x, food_y;

   food_placer #(.GRID_W(GW), .GRID_H(GH), .MAX_TRIES(MT)) dut (
      .clk(clk), .rst_n(rst_n), .place_req(place_req), .rnd_x(rnd_x), .rnd_y(rnd_y),
      .lfsr_en(lfsr_en), .occ_query(occ_query), .occ_x(occ_x), .occ_y(occ_y),
      .occ_valid(occ_valid), .occ_hit(occ_hit), .food_x(food_x), .food_y(food_y),
      .food_valid(food_valid), .busy(busy), .fail(fail)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Stimulus: LFSR value sequence and occupancy answers in query order
   logic [9:0]  rx[$], ry[$];
   bit          hits[$];
   bit          rand_delay;
   // Reference model results
   logic [11:0] exp_q[$];
   int          exp_nlfsr, exp_fail, exp_fv, exp_fx, exp_fy;
   int          last_fx = 0, last_fy = 0;
   // Observed timing of the last transaction, relative to the place_req cycle
   int          g_first_lfsr, g_first_q, g_resp, g_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic gen(input bit y_ok, input int hit_pct);
      rx.delete(); ry.delete(); hits.delete();
      for (int i = 0; i < 300; i++) begin
         rx.push_back(10'($urandom));
         if (y_ok) ry.push_back({4'($urandom), 6'($urandom_range(0, GH - 1))});
         else      ry.push_back(10'($urandom));
         hits.push_back($urandom_range(0, 99) < hit_pct);
      end
   endtask

   // Walk the candidate list: out-of-field or occupied candidates each cost a try.
   task automatic run_model();
      int tries, idx, qi, cx, cy;
      tries = 0; idx = 0; qi = 0;
      exp_q.delete();
      exp_nlfsr = 0; exp_fail = 0; exp_fv = 0; exp_fx = last_fx; exp_fy = last_fy;
      forever begin
         cx = int'(rx[idx] % 64);
         cy = int'(ry[idx] % 64);
         idx++;
         exp_nlfsr++;
         if (cx < GW && cy < GH) begin
            exp_q.push_back(12'(cx * 64 + cy));
            if (!hits[qi]) begin
               exp_fv = 1; exp_fx = cx; exp_fy = cy; last_fx = cx; last_fy = cy;
               break;
            end
            qi++;
         end
         tries++;
         if (tries == MT) begin
            exp_fail = 1;
            break;
         end
      end
   endtask

   task automatic run_txn(input string tag);
      int ptr, nlfsr, nfail, excl, busy_err, fv_err, pending, dly, qi, c0, got_n, done;
      bit adv;
      ptr = 0; nlfsr = 0; nfail = 0; excl = 0; busy_err = 0; fv_err = 0;
      pending = 0; dly = 0; qi = 0; got_n = 0; done = 0; adv = 0;
      g_first_lfsr = -1; g_first_q = -1; g_resp = -1; g_done = -1;
      run_model();
      @(negedge clk);
      rnd_x = rx[0]; rnd_y = ry[0]; place_req = 1'b1; occ_valid = 1'b0; occ_hit = 1'b0;
      c0 = cyc;
      for (int k = 0; k < 4000 && done == 0; k++) begin
         @(negedge clk);
         if (adv) begin ptr++; adv = 0; end
         occ_valid = 1'b0; occ_hit = 1'b0;
         if (pending != 0) begin
            if (dly == 0) begin
               occ_valid = 1'b1; occ_hit = hits[qi]; qi++; pending = 0;
               if (g_resp < 0) g_resp = cyc - c0;
            end else dly--;
         end else if ($urandom_range(0, 3) == 0) begin
            occ_valid = 1'b1;  // stray strobe outside WAIT
         end
         if (lfsr_en) begin
            nlfsr++; adv = 1;
            if (g_first_lfsr < 0) g_first_lfsr = cyc - c0;
         end
         if (lfsr_en && occ_query) excl++;
         if (occ_query) begin
            if (got_n < exp_q.size())
               chk({tag, ".query_xy"}, {20'b0, occ_x, occ_y}, {20'b0, exp_q[got_n]});
            got_n++; pending = 1;
            dly = rand_delay ? $urandom_range(0, 2) : 0;
            if (g_first_q < 0) g_first_q = cyc - c0;
         end
         if (fail) nfail++;
         if (busy && food_valid) fv_err++;
         if (food_valid || fail) begin
            done = 1; g_done = cyc - c0;
         end else if (!busy) busy_err++;
         place_req = busy ? 1'($urandom_range(0, 1)) : 1'b0;
         rnd_x = (ptr < rx.size()) ? rx[ptr] : 10'($urandom);
         rnd_y = (ptr < ry.size()) ? ry[ptr] : 10'($urandom);
      end
      chk({tag, ".done"}, done, 1);
      chk({tag, ".n_query"}, got_n, exp_q.size());
      chk({tag, ".n_lfsr"}, nlfsr, exp_nlfsr);
      chk({tag, ".n_fail"}, nfail, exp_fail);
      chk({tag, ".food_valid"}, food_valid, exp_fv);
      chk({tag, ".food_x"}, food_x, exp_fx);
      chk({tag, ".food_y"}, food_y, exp_fy);
      chk({tag, ".lfsr_query_overlap"}, excl, 0);
      chk({tag, ".busy_gap"}, busy_err, 0);
      chk({tag, ".valid_while_busy"}, fv_err, 0);
      @(negedge clk);
      occ_valid = 1'b0; place_req = 1'b0;
      chk({tag, ".after_busy"}, busy, 0);
      chk({tag, ".after_fail"}, fail, 0);
      chk({tag, ".after_valid"}, food_valid, exp_fv);
   endtask

   initial begin
      int seen, stray;
      rst_n = 1'b0; place_req = 1'b1; occ_valid = 1'b1; occ_hit = 1'b0;
      rnd_x = 10'h3ff; rnd_y = 10'h3ff; rand_delay = 1'b0;

      // Reset held two cycles with busy-looking inputs
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.lfsr_en", lfsr_en, 0);
      chk("rst.occ_query", occ_query, 0);
      chk("rst.occ_x", occ_x, 0);
      chk("rst.occ_y", occ_y, 0);
      chk("rst.food_x", food_x, 0);
      chk("rst.food_y", food_y, 0);
      chk("rst.food_valid", food_valid, 0);
      chk("rst.busy", busy, 0);
      chk("rst.fail", fail, 0);
      rst_n = 1'b1; place_req = 1'b0; occ_valid = 1'b0;
      @(negedge clk);
      chk("idle.busy", busy, 0);

      // Directed latency case: candidate (37,20), response at cycle 3
      gen(1'b1, 0);
      rx[0] = 10'h025; ry[0] = 10'h014;
      run_txn("latency");
      chk("latency.lfsr_cyc", g_first_lfsr, 1);
      chk("latency.query_cyc", g_first_q, 2);
      chk("latency.resp_cyc", g_resp, 3);
      chk("latency.valid_cyc", g_done, 4);
      chk("latency.food", {food_x, food_y}, {6'd37, 6'd20});

      // First candidate off the bottom edge, second accepted
      gen(1'b1, 0);
      ry[0] = {4'h5, 6'd50}; ry[1] = {4'h2, 6'd10};
      run_txn("range_reject");

      // Two occupied answers then a free one
      gen(1'b1, 0);
      hits[0] = 1'b1; hits[1] = 1'b1;
      run_txn("two_hits");

      // Every answer occupied: give up after MAX_TRIES
      rand_delay = 1'b1;
      gen(1'b1, 100);
      run_txn("exhaust");

      // Randomized placements
      for (int t = 0; t < 12; t++) begin
         gen(1'b0, $urandom_range(0, 70));
         run_txn($sformatf("rand%0d", t));
      end

      // Reset while waiting for the occupancy answer; late answer must be dropped
      gen(1'b1, 0);
      run_txn("pre_reset");
      @(negedge clk);
      rnd_x = 10'h011; rnd_y = 10'h005; place_req = 1'b1;
      seen = 0;
      for (int k = 0; k < 10 && seen == 0; k++) begin
         @(negedge clk);
         place_req = 1'b0;
         if (occ_query) seen = 1;
      end
      chk("wait_reset.query_seen", seen, 1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      occ_valid = 1'b1; occ_hit = 1'b0;
      @(negedge clk);
      occ_valid = 1'b0;
      stray = 0;
      repeat (4) begin
         @(negedge clk);
         stray += int'(fail) + int'(food_valid) + int'(busy) + int'(lfsr_en) + int'(occ_query);
      end
      chk("wait_reset.quiet", stray, 0);
      chk("wait_reset.food", {food_x, food_y}, 12'd0);
      last_fx = 0; last_fy = 0;

      gen(1'b0, 30);
      run_txn("post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/food_placer.md
FOOD_PLACER -- requirements
Module: food_placer

Interface
REQ-001 The block SHALL have parameter GRID_W, default 64, meaning playfield width in cells (1..64).
REQ-002 The block SHALL have parameter GRID_H, default 48, meaning playfield height in cells (1..64).
REQ-003 The block SHALL have parameter MAX_TRIES, default 255, meaning rejected candidates allowed before failure (1..255).
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port place_req  input  1  request a new food position; sampled only in IDLE.
REQ-007 Port rnd_x  input  10  current X output of the 10-bit LFSR.
REQ-008 Port rnd_y  input  10  current Y output of the 10-bit LFSR.
REQ-009 Port lfsr_en  output  1  advance-enable for the LFSR, one cycle per candidate.
REQ-010 Port occ_query  output  1  one-cycle pulse requesting a snake-body occupancy check.
REQ-011 Port occ_x  output  6  candidate cell X for the query.
REQ-012 Port occ_y  output  6  candidate cell Y for the query.
REQ-013 Port occ_valid  input  1  occupancy response strobe.
REQ-014 Port occ_hit  input  1  cell occupied by snake; qualified by occ_valid.
REQ-015 Port food_x  output  6  current food cell X.
REQ-016 Port food_y  output  6  current food cell Y.
REQ-017 Port food_valid  output  1  food position valid.
REQ-018 Port busy  output  1  placement in progress (state != IDLE).
REQ-019 Port fail  output  1  one-cycle pulse: MAX_TRIES rejections, no food placed.

Function
REQ-020 FSM states SHALL be IDLE, SAMPLE, QUERY, WAIT; all outputs registered.
REQ-021 IDLE: on place_req=1 -> SAMPLE next cycle; clear food_valid; clear 8-bit try counter; otherwise hold.
REQ-022 SAMPLE: lfsr_en=1 this cycle only; latch cand_x=rnd_x[5:0], cand_y=rnd_y[5:0] (pre-advance values).
REQ-023 SAMPLE range check: cand_x<GRID_W and cand_y<GRID_H -> QUERY; otherwise reject.
REQ-024 QUERY: occ_query=1 for exactly one cycle, occ_x/occ_y=cand_x/cand_y; -> WAIT.
REQ-025 WAIT: hold occ_x/occ_y; stay until occ_valid=1; no timeout.
REQ-026 WAIT, occ_valid=1, occ_hit=0: food_x/food_y<=cand, food_valid=1 next cycle; -> IDLE.
REQ-027 WAIT, occ_valid=1, occ_hit=1: reject.
REQ-028 Reject: try counter +1; new count==MAX_TRIES -> fail=1 one cycle, food_valid stays 0, food_x/food_y unchanged, -> IDLE; else -> SAMPLE.
REQ-029 Latency: place_req cycle 0, lfsr_en cycle 1, occ_query cycle 2, occ_valid at cycle n>=3 -> food_valid at n+1.
REQ-030 occ_valid outside WAIT SHALL be ignored; place_req while busy SHALL be ignored, not queued.
REQ-031 place_req in the cycle placement completes (transition to IDLE) SHALL be ignored; next request needs IDLE.
REQ-032 lfsr_en and occ_query SHALL never be high in the same cycle.

Reset
REQ-033 rst_n=0 at a rising edge SHALL force IDLE, try counter=0, food_x=0, food_y=0, food_valid=0, busy=0, fail=0, lfsr_en=0, occ_query=0, occ_x=0, occ_y=0.
REQ-034 Reset in any state, including WAIT, SHALL abort placement; a late occ_valid after reset SHALL be ignored.

Verification
REQ-035 Hold rst_n=0 2 cycles -> all outputs 0, busy=0.
REQ-036 place_req at cycle 0, rnd_x=0x025, rnd_y=0x014, occ_valid=1/occ_hit=0 at cycle 3 -> lfsr_en at 1, occ_query at 2 with (37,20), food (37,20) valid at cycle 4.
REQ-037 First rnd_y[5:0]=50 (>=48), next rnd_y[5:0]=10 -> no query for first; one query only, for second candidate; try counter 1.
REQ-038 occ_hit=1 on two responses, 0 on third -> exactly 3 occ_query pulses; food = third candidate.
REQ-039 occ_hit=1 on every response, MAX_TRIES=255 -> 255 queries, one fail pulse, food_valid=0, food_x/food_y unchanged.
REQ-040 rst_n=0 in WAIT, occ_valid=1 two cycles later -> IDLE, food_valid=0, no fail, response ignored.
